// File: rtl/connect4_pkg.sv
`default_nettype none
// ============================================================================
// connect4_pkg
// Shared board dimensions, direction codes and win-check sequencer states.
// Revision: 1.0 - initial release
// ============================================================================
package connect4_pkg;

  localparam int BOARD_ROWS = 6;
  localparam int BOARD_COLS = 7;

  localparam logic [3:0] DIR_NONE  = 4'd0;
  localparam logic [3:0] DIR_DOWN  = 4'd1;
  localparam logic [3:0] DIR_ROW_1 = 4'd2;
  localparam logic [3:0] DIR_ROW_2 = 4'd3;
  localparam logic [3:0] DIR_ROW_3 = 4'd4;
  localparam logic [3:0] DIR_ROW_4 = 4'd5;
  localparam logic [3:0] DIR_DRU_1 = 4'd6;
  localparam logic [3:0] DIR_DRU_2 = 4'd7;
  localparam logic [3:0] DIR_DRU_3 = 4'd8;
  localparam logic [3:0] DIR_DRU_4 = 4'd9;
  localparam logic [3:0] DIR_DLD_1 = 4'd10;
  localparam logic [3:0] DIR_DLD_2 = 4'd11;
  localparam logic [3:0] DIR_DLD_3 = 4'd12;
  localparam logic [3:0] DIR_DLD_4 = 4'd13;
  localparam logic [3:0] DIR_LAST  = DIR_DLD_4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dir_valid_lut.sv
`default_nettype none
// ============================================================================
// dir_valid_lut
// Combinational check that the 4-cell line for a direction fits on the board.
// Revision: 1.0 - initial release
// ============================================================================
module dir_valid_lut
  import connect4_pkg::*;
#(
  parameter int NUM_ROWS = BOARD_ROWS,
  parameter int NUM_COLS = BOARD_COLS
) (
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  input  logic [3:0] i_dir,
  output logic       o_valid
);

  localparam logic signed [5:0] c_row_max = 6'(NUM_ROWS - 1);
  localparam logic signed [5:0] c_col_max = 6'(NUM_COLS - 1);

  logic signed [5:0] w_dr;
  logic signed [5:0] w_dc;
  logic signed [5:0] w_k;
  logic              w_known;
  logic signed [5:0] w_row_s;
  logic signed [5:0] w_col_s;
  logic signed [5:0] w_r_lo;
  logic signed [5:0] w_r_hi;
  logic signed [5:0] w_c_lo;
  logic signed [5:0] w_c_hi;

  function automatic logic in_range(input logic signed [5:0] v,
                                    input logic signed [5:0] vmax);
    return (v >= 6'sd0) && (v <= vmax);
  endfunction

  // Each direction is a step (dr,dc) plus the index k of the dropped piece
  // within the line; the line spans offsets -k .. 3-k along that step.
  always_comb begin
    w_dr    = 6'sd0;
    w_dc    = 6'sd0;
    w_k     = 6'sd0;
    w_known = 1'b1;
    case (i_dir)
      DIR_DOWN:  begin w_dr = -6'sd1;                             end
      DIR_ROW_1: begin w_dc =  6'sd1; w_k = 6'sd3;                end
      DIR_ROW_2: begin w_dc =  6'sd1; w_k = 6'sd2;                end
      DIR_ROW_3: begin w_dc =  6'sd1; w_k = 6'sd1;                end
      DIR_ROW_4: begin w_dc =  6'sd1;                             end
      DIR_DRU_1: begin w_dr =  6'sd1; w_dc = 6'sd1; w_k = 6'sd3;  end
      DIR_DRU_2: begin w_dr =  6'sd1; w_dc = 6'sd1; w_k = 6'sd2;  end
      DIR_DRU_3: begin w_dr =  6'sd1; w_dc = 6'sd1; w_k = 6'sd1;  end
      DIR_DRU_4: begin w_dr =  6'sd1; w_dc = 6'sd1;               end
      DIR_DLD_1: begin w_dr = -6'sd1; w_dc = 6'sd1; w_k = 6'sd3;  end
      DIR_DLD_2: begin w_dr = -6'sd1; w_dc = 6'sd1; w_k = 6'sd2;  end
      DIR_DLD_3: begin w_dr = -6'sd1; w_dc = 6'sd1; w_k = 6'sd1;  end
      DIR_DLD_4: begin w_dr = -6'sd1; w_dc = 6'sd1;               end
      default:   begin w_known = 1'b0;                            end
    endcase
  end

  assign w_row_s = signed'({3'b000, i_row});
  assign w_col_s = signed'({3'b000, i_col});
  assign w_r_lo  = w_row_s - (w_k * w_dr);
  assign w_r_hi  = w_row_s + ((6'sd3 - w_k) * w_dr);
  assign w_c_lo  = w_col_s - (w_k * w_dc);
  assign w_c_hi  = w_col_s + ((6'sd3 - w_k) * w_dc);

  assign o_valid = w_known
                && in_range(w_r_lo, c_row_max) && in_range(w_r_hi, c_row_max)
                && in_range(w_c_lo, c_col_max) && in_range(w_c_hi, c_col_max);

endmodule
`default_nettype wire

// File: rtl/win_check_sequencer.sv
`default_nettype none
// ============================================================================
// win_check_sequencer
// Steps the direction checker through every fitting direction after a drop
// and owns the board read port. WIN_ALL_LINES_EN: keep checking after a win.
// Revision: 1.0 - initial release
// ============================================================================
module win_check_sequencer
  import connect4_pkg::*;
#(
  parameter int NUM_ROWS = BOARD_ROWS,
  parameter int NUM_COLS = BOARD_COLS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] row,
  input  logic [2:0] col,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic [3:0] win_dir,
  output logic       chk_start,
  output logic [2:0] chk_row,
  output logic [2:0] chk_col,
  output logic [3:0] chk_direction,
  input  logic       chk_finished,
  input  logic [1:0] chk_winner,
  input  logic [2:0] chk_read_row,
  input  logic [2:0] chk_read_col,
  input  logic [2:0] ext_read_row,
  input  logic [2:0] ext_read_col,
  output logic [2:0] mem_read_row,
  output logic [2:0] mem_read_col
);

  seq_state_t r_state;
  logic [3:0] r_dir;
  logic [2:0] r_row;
  logic [2:0] r_col;
  logic       r_busy;
  logic       r_done;
  logic [1:0] r_winner;
  logic [3:0] r_win_dir;
  logic       r_chk_start;
  logic [3:0] r_chk_dir;
  logic       w_valid;
  logic       w_first_win;

  dir_valid_lut #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_dir_valid_lut (
    .i_row   (r_row),
    .i_col   (r_col),
    .i_dir   (r_dir),
    .o_valid (w_valid)
  );

  assign w_first_win = (chk_winner != 2'b00) && (r_winner == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_NONE;
      r_row       <= '0;
      r_col       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= 2'b00;
      r_win_dir   <= DIR_NONE;
      r_chk_start <= 1'b0;
      r_chk_dir   <= DIR_NONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row     <= row;
            r_col     <= col;
            r_dir     <= DIR_DOWN;
            r_winner  <= 2'b00;
            r_win_dir <= DIR_NONE;
            r_busy    <= 1'b1;
            r_state   <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_dir > DIR_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_valid) begin
            r_chk_dir   <= r_dir;
            r_chk_start <= 1'b1;
            r_state     <= S_LAUNCH;
          end else begin
            r_dir <= r_dir + 4'd1;
          end
        end
        S_LAUNCH: begin
          r_chk_start <= 1'b0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (chk_finished) begin
            if (w_first_win) begin
              r_winner  <= chk_winner;
              r_win_dir <= r_dir;
            end
`ifdef WIN_ALL_LINES_EN
            r_dir   <= r_dir + 4'd1;
            r_state <= S_SELECT;
`else
            if (chk_winner != 2'b00) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dir   <= r_dir + 4'd1;
              r_state <= S_SELECT;
            end
`endif
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign winner        = r_winner;
  assign win_dir       = r_win_dir;
  assign chk_start     = r_chk_start;
  assign chk_row       = r_row;
  assign chk_col       = r_col;
  assign chk_direction = r_chk_dir;

  // The checker owns the read port for the whole sequence.
  assign mem_read_row = r_busy ? chk_read_row : ext_read_row;
  assign mem_read_col = r_busy ? chk_read_col : ext_read_col;

endmodule
`default_nettype wire
